// File: rtl/ps2_rx_frame_if.sv
// rtl/ps2_rx_frame_if.sv - PS/2 receiver pin/byte bundle shared by the host side and the receiver
interface ps2_rx_frame_if;

  // Raw, asynchronous PS/2 lines plus the frame-start enable
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;

  // Byte-wide result towards the scan-code validation chain
  logic [7:0] datos;
  logic       rx_done_tick;
  logic       frame_err;

  // Side that drives the PS/2 lines and consumes the received bytes
  modport master (
    output ps2c,
    output ps2d,
    output rx_en,
    input  datos,
    input  rx_done_tick,
    input  frame_err
  );

  // Receiver side
  modport slave (
    input  ps2c,
    input  ps2d,
    input  rx_en,
    output datos,
    output rx_done_tick,
    output frame_err
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 11-bit frame receiver with clock deglitch, framing check and timeout (optional parity check: PS2_PARITY_CHECK_EN)
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           reset,
  ps2_rx_frame_if.slave  bus
);

  // Timeout counter width; TIMEOUT_CYCLES must stay below 2^20.
  localparam int         TW       = 20;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Input conditioning
  logic                  ps2c_meta_q, ps2c_s_q;
  logic                  ps2d_meta_q, ps2d_s_q;
  logic [FILTER_LEN-1:0] filter_q;
  logic                  fclk_q, fclk_d;
  logic                  fclk_dly_q;
  logic                  fall;

  // Frame FSM and datapath
  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [9:0]            b_q, b_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [7:0]            datos_q, datos_d;
  logic                  frame_good;
  logic                  done_tick;
  logic                  err_tick;

  // Two-flop synchronizers; idle-high reset keeps the lines looking released.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_s_q    <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_s_q    <= 1'b1;
    end else begin
      ps2c_meta_q <= bus.ps2c;
      ps2c_s_q    <= ps2c_meta_q;
      ps2d_meta_q <= bus.ps2d;
      ps2d_s_q    <= ps2d_meta_q;
    end
  end

  // Filtered clock only moves once the whole history window agrees.
  always_comb begin
    fclk_d = fclk_q;
    if (&filter_q) begin
      fclk_d = 1'b1;
    end else if (~|filter_q) begin
      fclk_d = 1'b0;
    end
  end

  // Deglitch shift register, filtered clock and its delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      filter_q   <= '1;
      fclk_q     <= 1'b1;
      fclk_dly_q <= 1'b1;
    end else begin
      filter_q   <= {filter_q[FILTER_LEN-2:0], ps2c_s_q};
      fclk_q     <= fclk_d;
      fclk_dly_q <= fclk_q;
    end
  end

  // One-cycle pulse on each falling edge of the filtered PS/2 clock.
  assign fall = fclk_dly_q & ~fclk_q;

  // Stop bit must be 1; with parity checking, data plus parity must hold an odd number of ones.
`ifdef PS2_PARITY_CHECK_EN
  assign frame_good = b_q[9] & (^b_q[8:0]);
`else
  assign frame_good = b_q[9];
`endif

  // Next-state logic: start detection, bit shifting, timeout, frame check and byte strobe.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    b_d       = b_q;
    tcnt_d    = tcnt_q;
    datos_d   = datos_q;
    done_tick = 1'b0;
    err_tick  = 1'b0;

    case (state_q)
      IDLE: begin
        // Starts are only taken from IDLE itself, so an edge coinciding
        // with the return to IDLE is never mistaken for a start bit.
        if (fall && bus.rx_en && !ps2d_s_q) begin
          n_d     = 4'd9;
          tcnt_d  = '0;
          state_d = DPS;
        end
      end

      DPS: begin
        if (fall) begin
          b_d    = {ps2d_s_q, b_q[9:1]};
          tcnt_d = '0;
          if (n_q == 4'd0) begin
            state_d = CHK;
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (tcnt_q == TO_LAST) begin
          // Keyboard stopped clocking mid-frame: drop the partial byte.
          err_tick = 1'b1;
          tcnt_d   = '0;
          state_d  = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      CHK: begin
        if (frame_good) begin
          datos_d = b_q[7:0];
          state_d = DONE;
        end else begin
          err_tick = 1'b1;
          state_d  = IDLE;
        end
      end

      DONE: begin
        done_tick = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any partial frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      b_q     <= '0;
      tcnt_q  <= '0;
      datos_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tcnt_q  <= tcnt_d;
      datos_q <= datos_d;
    end
  end

  // Strobes come straight from the FSM so they are one cycle wide and mutually exclusive.
  assign bus.datos        = datos_q;
  assign bus.rx_done_tick = done_tick;
  assign bus.frame_err    = err_tick;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - directed self-checking bench for ps2_rx_frame
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int HALF = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tick_n   = 0;
  int err_n    = 0;
  int both_n   = 0;
  int tick_cyc = -1;
  int err_cyc  = -1;

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      tick_n   = tick_n + 1;
      tick_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) begin
      err_n   = err_n + 1;
      err_cyc = cyc;
    end
    if (bus.rx_done_tick === 1'b1 && bus.frame_err === 1'b1) both_n = both_n + 1;
  end

  int compared   = 0;
  int mismatched = 0;
  int stop_drv   = 0;
  int t0, e0;
  logic [7:0] exp_datos;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit flip_par, input bit stop);
    return {stop, (~^d) ^ flip_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int nbits, input int drop_en_at, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2d = frame[i];
      repeat (HALF) @(negedge clk);
      if (i == glitch_at) begin
        bus.ps2c = 1'b0;
        repeat (FL - 1) @(negedge clk);
        bus.ps2c = 1'b1;
        repeat (HALF) @(negedge clk);
      end
      bus.ps2c = 1'b0;
      stop_drv = cyc;
      if (i == drop_en_at) bus.rx_en = 1'b0;
      repeat (HALF) @(negedge clk);
      bus.ps2c = 1'b1;
    end
    bus.ps2d = 1'b1;
  endtask

  task automatic snap();
    t0 = tick_n;
    e0 = err_n;
  endtask

  initial begin
    bus.ps2c  = 1'b1;
    bus.ps2d  = 1'b1;
    bus.rx_en = 1'b1;
    exp_datos = 8'h00;
    repeat (5) @(negedge clk);
    chk("reset_datos", bus.datos, 8'h00);
    chk("reset_tick", bus.rx_done_tick, 1'b0);
    chk("reset_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame 0x1C
    snap();
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'h1C;
    chk("f1c_ticks", tick_n - t0, 1);
    chk("f1c_errs", err_n - e0, 0);
    chk("f1c_datos", bus.datos, exp_datos);
    chk("f1c_tick_time", tick_cyc, stop_drv + 13);

    // Back-to-back 0xF0 then 0x1C
    snap();
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, -1, -1);
    chk("b2b_datos_f0", bus.datos, 8'hF0);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'h1C;
    chk("b2b_ticks", tick_n - t0, 2);
    chk("b2b_errs", err_n - e0, 0);
    chk("b2b_datos_1c", bus.datos, exp_datos);

    // Bad parity 0x1C after a good 0xF0
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'hF0;
    snap();
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_ticks", tick_n - t0, 0);
    chk("par_errs", err_n - e0, 1);
    chk("par_err_time", err_cyc, stop_drv + 12);
`else
    exp_datos = 8'h1C;
    chk("par_ticks", tick_n - t0, 1);
    chk("par_errs", err_n - e0, 0);
    chk("par_tick_time", tick_cyc, stop_drv + 13);
`endif
    chk("par_datos", bus.datos, exp_datos);

    // Bad stop bit
    snap();
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11, -1, -1);
    repeat (20) @(negedge clk);
    chk("stop_ticks", tick_n - t0, 0);
    chk("stop_errs", err_n - e0, 1);
    chk("stop_err_time", err_cyc, stop_drv + 12);
    chk("stop_datos", bus.datos, exp_datos);

    // Short ps2c glitches in IDLE (data low) and mid-frame
    snap();
    bus.ps2d = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2c = 1'b0;
    repeat (FL - 1) @(negedge clk);
    bus.ps2c = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("glitch_idle_errs", err_n - e0, 0);
    send_bits(mk(8'h29, 1'b0, 1'b1), 11, -1, 4);
    repeat (20) @(negedge clk);
    exp_datos = 8'h29;
    chk("glitch_ticks", tick_n - t0, 1);
    chk("glitch_errs", err_n - e0, 0);
    chk("glitch_datos", bus.datos, exp_datos);

    // Timeout after five bits, then recovery with 0x29
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'h1C;
    snap();
    send_bits(mk(8'h29, 1'b0, 1'b1), 5, -1, -1);
    repeat (TO + 40) @(negedge clk);
    chk("to_errs", err_n - e0, 1);
    chk("to_err_time", err_cyc, stop_drv + TO + 11);
    chk("to_ticks", tick_n - t0, 0);
    chk("to_datos", bus.datos, exp_datos);
    snap();
    send_bits(mk(8'h29, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'h29;
    chk("to_rec_ticks", tick_n - t0, 1);
    chk("to_rec_datos", bus.datos, exp_datos);

    // rx_en dropped mid-frame still completes; frame with rx_en low is ignored
    snap();
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, 3, -1);
    repeat (20) @(negedge clk);
    exp_datos = 8'hF0;
    chk("en_drop_ticks", tick_n - t0, 1);
    chk("en_drop_datos", bus.datos, exp_datos);
    snap();
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    chk("en_off_ticks", tick_n - t0, 0);
    chk("en_off_errs", err_n - e0, 0);
    chk("en_off_datos", bus.datos, exp_datos);
    bus.rx_en = 1'b1;
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame
    snap();
    send_bits(mk(8'h1C, 1'b0, 1'b1), 5, -1, -1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_datos", bus.datos, 8'h00);
    chk("rst_mid_tick", bus.rx_done_tick, 1'b0);
    reset = 1'b0;
    repeat (TO + 40) @(negedge clk);
    chk("rst_mid_errs", err_n - e0, 0);
    snap();
    send_bits(mk(8'h29, 1'b0, 1'b1), 11, -1, -1);
    repeat (20) @(negedge clk);
    chk("rst_rec_ticks", tick_n - t0, 1);
    chk("rst_rec_errs", err_n - e0, 0);
    chk("rst_rec_datos", bus.datos, 8'h29);
    chk("rst_rec_tick_time", tick_cyc, stop_drv + 13);

    chk("never_both", both_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ps2_rx_frame.md
# ps2_rx_frame

PS/2 serial receiver that turns the raw keyboard clock/data lines into byte-wide scan codes. It is the stage that drives `datos[7:0]` and `rx_done_tick` into the F0-detection/validation chain of the keyboard path. It synchronizes and deglitches the PS/2 clock, deserializes the 11-bit frame, checks framing, and emits one-cycle byte strobes.

## Interface

- `FILTER_LEN`, 8: number of consecutive identical synchronized `ps2c` samples needed to change the filtered clock.
- `TIMEOUT_CYCLES`, 100000: idle clock cycles between PS/2 falling edges that abort a partial frame. This is 2 ms at 50 MHz. Must be < 2^20.
- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `ps2c`  in  1: raw PS/2 clock pin. Asynchronous.
- `ps2d`  in  1: raw PS/2 data pin. Asynchronous.
- `rx_en`  in  1: when high, a new frame may start. It does not affect a frame already in progress.
- `datos`  out  8: last correctly received byte. Held until the next good frame.
- `rx_done_tick`  out  1: one-cycle strobe when `datos` has just been updated.
- `frame_err`  out  1: one-cycle strobe when a frame is discarded.

## Operation

**Input conditioning**
- `ps2c` and `ps2d` pass through 2-flop synchronizers.
- `FILTER_LEN`-bit shift register on synchronized `ps2c`:
  - filtered clock `fclk` goes to 1 when all bits are 1;
  - `fclk` goes to 0 when all bits are 0;
  - otherwise `fclk` holds.
- `fall = fclk_q & ~fclk`, a one-cycle pulse.

**Frame format**
- 11 bits: start (0), 8 data bits LSB first, odd parity, stop (1).
- Bits are sampled from synchronized `ps2d` in the cycle `fall` is high.

**FSM**
- IDLE:
  - on `fall & rx_en & ps2d_s==0`: bit counter `n` ← 9, timeout counter ← 0, go to DPS.
  - `fall` with `ps2d_s==1`, or with `rx_en==0`: ignored, stay in IDLE.
- DPS:
  - on `fall`: shift `b[9:0]` ← `{ps2d_s, b[9:1]}` and clear the timeout counter.
  - if `n==0` go to CHK, else `n` ← `n-1`.
  - without `fall`: timeout counter increments; on reaching `TIMEOUT_CYCLES-1`, go to IDLE and pulse `frame_err`.
- CHK (one cycle):
  - frame is good if `b[9]==1`, plus the parity rule from Configuration.
  - good frame: `datos` ← `b[7:0]`, go to DONE.
  - bad frame: pulse `frame_err`, `datos` unchanged, go to IDLE.
- DONE (one cycle): `rx_done_tick`=1, go to IDLE.

**Boundary conditions**
- `rx_en` falling mid-frame: frame completes normally.
- Start-bit `fall` arriving in the same cycle the FSM returns to IDLE (from DONE, CHK or a timeout): not accepted. A frame starts only from a `fall` seen while already in IDLE.

**Reset**
- FSM to IDLE; `n`, `b`, timeout counter to 0.
- Filter register and `fclk` to all-ones/1, so no spurious edge after reset.
- `datos`=0x00, `rx_done_tick`=0, `frame_err`=0.
- Reset mid-frame discards the partial frame with no `frame_err`.

## Timing

- `fall` asserts `FILTER_LEN+2` cycles after the first `clk` edge that samples `ps2c` low, provided `ps2c` stays low.
- Stop-bit `fall` in cycle T:
  - T+1 = CHK;
  - T+2 = DONE: `rx_done_tick` high and the new `datos` visible in the same cycle.
- `frame_err` asserts at T+1 for framing/parity errors.
- `frame_err` asserts in the cycle the timeout counter reaches `TIMEOUT_CYCLES-1` for a timeout.
- `rx_done_tick` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide.
- Minimum `clk` requirement: low/high phases of `ps2c` ≥ `FILTER_LEN+3` cycles. Met by the 10–16.7 kHz PS/2 clock at ≥ 1 MHz.

## Configuration

- `PS2_PARITY_CHECK_EN` defined:
  - CHK also requires odd parity, i.e. XOR of `b[8:0]` == 1;
  - a parity failure pulses `frame_err` and drops the byte.
- Not defined:
  - `b[8]` is shifted but ignored;
  - only the stop bit is checked;
  - a bad-parity frame with a valid stop bit produces `rx_done_tick`.

## Test plan

- Frame 0x1C, parity 0, stop 1, `rx_en`=1 → `datos`=0x1C, single `rx_done_tick` at stop-fall+2, `frame_err`=0.
- Frames 0xF0 (parity 1) then 0x1C back-to-back → two ticks, `datos` 0xF0 then 0x1C.
- 0x1C with parity 1:
  - macro on → one `frame_err`, no tick, `datos` holds the prior value;
  - macro off → tick, `datos`=0x1C.
- 0x1C with stop bit 0 → `frame_err` at stop-fall+1, no tick, `datos` unchanged.
- `ps2c` glitch low for `FILTER_LEN-1` cycles in IDLE and mid-frame → no `fall`; the following frame 0x29 is received correctly.
- Five bits, then `ps2c` held high → `frame_err` after `TIMEOUT_CYCLES`; next frame 0x29 → tick, `datos`=0x29.
- `reset` asserted mid-frame → outputs 0, no `frame_err`; the next frame decodes correctly.
